log_div_lut_loader: RTL

Front-end controller placed directly upstream of the float16 log-scale divider. After every reset, and on request, it streams the divider's 128-entry log2 and exp2 lookup tables from an external coefficient ROM. It pulses the divider's reset so the divider's write pointer restarts at entry 0. Once the tables are loaded, it accepts operands through a valid/ready handshake and returns each quotient tagged with `out_valid`.

---
 rtl/log_div_pkg.sv | 23 ++
 rtl/log_div_valid_pipe.sv | 26 ++
 rtl/log_div_lut_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/log_div_pkg.sv
// Shared widths, table geometry and FSM encoding for the log-scale divider front end.
package log_div_pkg;

  localparam int unsigned FLOAT_LEN   = 16;
  localparam int unsigned MANT_LEN    = 10;
  localparam int unsigned LUT_SIZE    = 128;
  localparam int unsigned DIV_LATENCY = 2;
  localparam int unsigned ADDR_W      = $clog2(LUT_SIZE);
  localparam int unsigned PIPE_DEPTH  = DIV_LATENCY + 1;

  localparam logic [FLOAT_LEN-1:0] F16_QNAN = 16'h7E00;
  localparam logic [FLOAT_LEN-1:0] F16_PINF = 16'h7C00;
  localparam logic [FLOAT_LEN-1:0] F16_ONE  = 16'h3C00;

  typedef enum logic [2:0] {
    StFlush,
    StDivRst,
    StFetch,
    StDrain,
    StReady
  } lut_ld_state_t;

endpackage

// File: rtl/log_div_valid_pipe.sv
// Valid-bit delay line that shadows the divider pipeline so results can be tagged.
module log_div_valid_pipe #(
  parameter int unsigned Depth = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic push,
  output logic tail,
  output logic empty
);

  logic [Depth-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[Depth-2:0], push};
    end
  end

  assign tail  = stage_q[Depth-1];
  // Nothing stays in flight after the next shift (the tail leaves on that edge).
  assign empty = ~|stage_q[Depth-2:0];

endmodule

// File: rtl/log_div_lut_loader.sv
// Loads the divider's log2/exp2 tables from ROM after reset or on request, then
// forwards operands to the divider and tags its results with out_valid.
module log_div_lut_loader
  import log_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  output logic                 rom_rd,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [MANT_LEN-1:0]  rom_log2_data,
  input  logic [FLOAT_LEN-1:0] rom_exp2_data,
  output logic                 div_rst_n,
  output logic                 lut_wr_en,
  output logic [MANT_LEN-1:0]  log2_lut_data_out,
  output logic [FLOAT_LEN-1:0] exp2_lut_data_out,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] in_a,
  input  logic [FLOAT_LEN-1:0] in_b,
  output logic [FLOAT_LEN-1:0] div_a,
  output logic [FLOAT_LEN-1:0] div_b,
  input  logic [FLOAT_LEN-1:0] div_result,
  output logic                 out_valid,
  output logic [FLOAT_LEN-1:0] out_result,
  output logic                 busy,
  output logic                 load_done
);

  lut_ld_state_t        state_q;
  logic                 rom_rd_q;
  logic [ADDR_W-1:0]    rom_addr_q;
  logic                 div_rst_n_q;
  logic                 lut_wr_en_q;
  logic                 in_ready_q;
  logic                 load_done_q;
  logic                 busy_q;
  logic [FLOAT_LEN-1:0] div_a_q;
  logic [FLOAT_LEN-1:0] div_b_q;
  logic                 out_valid_q;
  logic [FLOAT_LEN-1:0] out_result_q;

  logic accept;
  logic pipe_tail;
  logic pipe_empty;

  assign accept = in_valid & in_ready_q;

  log_div_valid_pipe #(
    .Depth(PIPE_DEPTH)
  ) u_valid_pipe (
    .clk  (clk),
    .clr  (rst),
    .push (accept),
    .tail (pipe_tail),
    .empty(pipe_empty)
  );

  // rom_addr_q doubles as the fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDivRst;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      div_rst_n_q <= 1'b0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StDivRst: begin
          state_q     <= StFetch;
          div_rst_n_q <= 1'b1;
          rom_rd_q    <= 1'b1;
          rom_addr_q  <= '0;
        end
        StFetch: begin
          if (rom_addr_q == ADDR_W'(LUT_SIZE - 1)) begin
            state_q    <= StDrain;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
          end else begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          state_q     <= StReady;
          in_ready_q  <= 1'b1;
          load_done_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        StReady: begin
          if (load_start) begin
            in_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b1;
            // Skip the flush entirely when nothing would still be in flight.
            if (!accept && pipe_empty) begin
              state_q     <= StDivRst;
              div_rst_n_q <= 1'b0;
            end else begin
              state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          if (pipe_empty) begin
            state_q     <= StDivRst;
            div_rst_n_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StDivRst;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_wr_en_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      lut_wr_en_q <= rom_rd_q;
      if (accept) begin
        div_a_q <= in_a;
        div_b_q <= in_b;
      end
      out_valid_q  <= pipe_tail;
      out_result_q <= pipe_tail ? div_result : '0;
    end
  end

  // ROM data arrives in the write cycle; gate it so idle cycles present zeros.
  assign log2_lut_data_out = lut_wr_en_q ? rom_log2_data : '0;
  assign exp2_lut_data_out = lut_wr_en_q ? rom_exp2_data : '0;

  assign rom_rd     = rom_rd_q;
  assign rom_addr   = rom_addr_q;
  assign div_rst_n  = div_rst_n_q;
  assign lut_wr_en  = lut_wr_en_q;
  assign in_ready   = in_ready_q;
  assign load_done  = load_done_q;
  assign busy       = busy_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule
